// File: rtl/wave_mode_pkg.sv
// ============================================================================
// wave_mode_pkg : shared types and mode-step helpers for wave_mode_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package wave_mode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BLINK = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEXT = 2'd1,
        DIR_PREV = 2'd2
    } press_dir_e;

    function automatic int next_mode(input int mode, input int n_modes);
        return (mode == n_modes - 1) ? 0 : mode + 1;
    endfunction

    function automatic int prev_mode(input int mode, input int n_modes);
        return (mode == 0) ? n_modes - 1 : mode - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_mode_timer.sv
// ============================================================================
// wave_mode_timer : clear/enable up-counter that saturates at a terminal value
// Rev 1.0
// ============================================================================
`default_nettype none

module wave_mode_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Holds at the terminal value so a missed state change can never wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != i_term)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_term);

endmodule

`default_nettype wire

// File: rtl/wave_mode_ctrl.sv
// ============================================================================
// wave_mode_ctrl : NEXT/PREV waveform selector with req/ack commit and LED blink
// Rev 1.0
// ============================================================================
`default_nettype none

module wave_mode_ctrl
    import wave_mode_pkg::*;
#(
    parameter int N_MODES      = 4,
    parameter int MODE_W       = 2,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_next,
    input  logic              i_prev,
    input  logic              i_ack,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_req,
    output logic              o_busy,
    output logic              o_led,
    output logic              o_err
);

    localparam int TMR_MAX = (ACK_TIMEOUT > BLINK_CYCLES) ? ACK_TIMEOUT : BLINK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_e            r_state, w_state_nxt;
    press_dir_e        r_pend,  w_pend_nxt;
    logic [MODE_W-1:0] r_mode,  w_mode_nxt;
    logic [MODE_W-1:0] r_commit, w_commit_nxt;
    logic              r_err,   w_err_nxt;

    press_dir_e        w_dir;
    press_dir_e        w_step_dir;
    logic [MODE_W-1:0] w_mode_step;
    logic [TMR_W-1:0]  w_term;
    logic              w_tc;
    logic              w_tmr_clr;

    // Simultaneous NEXT and PREV cancel each other out.
    always_comb begin
        w_dir = DIR_NONE;
        case ({i_next, i_prev})
            2'b10:   w_dir = DIR_NEXT;
            2'b01:   w_dir = DIR_PREV;
            default: w_dir = DIR_NONE;
        endcase
    end

    assign w_step_dir  = (r_pend != DIR_NONE) ? r_pend : w_dir;
    assign w_mode_step = (w_step_dir == DIR_PREV) ? MODE_W'(prev_mode(int'(r_mode), N_MODES))
                                                  : MODE_W'(next_mode(int'(r_mode), N_MODES));

    assign w_term    = (r_state == REQ) ? TMR_W'(ACK_TIMEOUT - 1) : TMR_W'(BLINK_CYCLES - 1);
    assign w_tmr_clr = (w_state_nxt != r_state) || (r_state == IDLE);

    wave_mode_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_tmr_clr),
        .i_en   (1'b1),
        .i_term (w_term),
        .o_tc   (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_pend   <= DIR_NONE;
            r_mode   <= '0;
            r_commit <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_mode   <= w_mode_nxt;
            r_commit <= w_commit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_mode_nxt   = r_mode;
        w_commit_nxt = r_commit;
        w_err_nxt    = r_err;
        case (r_state)
            IDLE: begin
                if (w_step_dir != DIR_NONE) begin
                    w_commit_nxt = r_mode;
                    w_mode_nxt   = w_mode_step;
                    w_pend_nxt   = DIR_NONE;
                    w_state_nxt  = REQ;
                end
            end
            REQ: begin
                if (r_pend == DIR_NONE) begin
                    w_pend_nxt = w_dir;
                end
                if (i_ack) begin
                    w_commit_nxt = r_mode;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = BLINK;
                end else if (w_tc) begin
                    w_mode_nxt  = r_commit;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            BLINK: begin
                if (r_pend == DIR_NONE) begin
                    w_pend_nxt = w_dir;
                end
                if (w_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_mode = r_mode;
    assign o_req  = (r_state == REQ);
    assign o_busy = (r_state != IDLE);
    assign o_led  = (r_state == BLINK);
    assign o_err  = r_err;

endmodule

`default_nettype wire
